// File: rtl/cla_sum_stage_pkg.sv
// Shared constants and payload types for the carry-lookahead sum stage.
package cla_sum_stage_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned GRP   = 4;
    localparam int unsigned NGRP  = WIDTH / GRP;

    // Result flags, in the order they are presented on the output bus.
    typedef struct packed {
        logic cout;
        logic v;
        logic z;
        logic n;
    } flags_t;

    // Operands and lookahead terms captured by stage 1. The tag travels beside
    // this record because its width is a parameter of the stage.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NGRP:0]    c;
    } payload_t;

endpackage

// File: rtl/cla_group_sum.sv
// One 4-bit lookahead group: ripples the group carry-in across the group
// using G/P and forms the sum bits from the raw operands.
module cla_group_sum
    import cla_sum_stage_pkg::*;
(
    input  logic [GRP-1:0] a_i,
    input  logic [GRP-1:0] b_i,
    input  logic [GRP-1:0] g_i,
    input  logic [GRP-1:0] p_i,
    input  logic           cin_i,
    output logic [GRP-1:0] sum_o
);

    logic [GRP-1:0] carry_c;

    // In-group carries; P is OR-form, so the sum XOR uses a^b rather than p.
    always_comb begin
        carry_c    = '0;
        carry_c[0] = cin_i;
        for (int unsigned i = 0; i < GRP - 1; i++) begin
            carry_c[i+1] = g_i[i] | (p_i[i] & carry_c[i]);
        end
        sum_o = a_i ^ b_i ^ carry_c;
    end

endmodule

// File: rtl/cla_sum_stage.sv
// Two-register sum stage behind the 32-bit lookahead unit: stage 1 captures
// operands and group carries, stage 2 registers the sum and flags. Both
// stages use a valid/ready skid-free handshake for one result per cycle.
module cla_sum_stage
    import cla_sum_stage_pkg::*;
#(
    parameter int unsigned TAG_W = 4
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] G,
    input  logic [WIDTH-1:0] P,
    input  logic [NGRP:0]    C,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             Z,
    output logic             N,
    output logic [TAG_W-1:0] tag_out
);

    logic             s1_valid_q, s1_valid_d;
    payload_t         s1_q, s1_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_sum_q, s2_sum_d;
    flags_t           s2_flags_q, s2_flags_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic             adv1_c, adv2_c;
    logic [WIDTH-1:0] sum_c;
    flags_t           flags_c;

    // A stage may advance when it is empty or the stage after it is moving.
    assign adv2_c = ~s2_valid_q | out_ready;
    assign adv1_c = ~s1_valid_q | adv2_c;

    // Eight groups, each seeded with its lookahead carry.
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        cla_group_sum u_grp (
            .a_i   (s1_q.a[gi*GRP +: GRP]),
            .b_i   (s1_q.b[gi*GRP +: GRP]),
            .g_i   (s1_q.g[gi*GRP +: GRP]),
            .p_i   (s1_q.p[gi*GRP +: GRP]),
            .cin_i (s1_q.c[gi]),
            .sum_o (sum_c[gi*GRP +: GRP])
        );
    end

    // Flags from the captured operands and the freshly formed sum.
    always_comb begin
        flags_c      = '0;
        flags_c.cout = s1_q.c[NGRP];
        flags_c.v    = (s1_q.a[WIDTH-1] == s1_q.b[WIDTH-1]) &
                       (sum_c[WIDTH-1] != s1_q.a[WIDTH-1]);
        flags_c.z    = ~|sum_c;
        flags_c.n    = sum_c[WIDTH-1];
    end

    // Next state for both stages; data registers only load with valid data.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        s1_tag_d   = s1_tag_q;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        s2_flags_d = s2_flags_q;
        s2_tag_d   = s2_tag_q;

        if (adv2_c) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sum_d   = sum_c;
                s2_flags_d = flags_c;
                s2_tag_d   = s1_tag_q;
            end
        end

        if (adv1_c) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_d.a   = A;
                s1_d.b   = B;
                s1_d.g   = G;
                s1_d.p   = P;
                s1_d.c   = C;
                s1_tag_d = tag_in;
            end
        end
    end

    // Pipeline registers; reset empties both stages and zeroes all data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_flags_q <= '0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_q       <= s1_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_flags_q <= s2_flags_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign in_ready  = adv1_c;
    assign out_valid = s2_valid_q;
    assign S         = s2_sum_q;
    assign Cout      = s2_flags_q.cout;
    assign V         = s2_flags_q.v;
    assign Z         = s2_flags_q.z;
    assign N         = s2_flags_q.n;
    assign tag_out   = s2_tag_q;

endmodule

// File: tb/tb_cla_sum_stage.sv
// Bench for cla_sum_stage: directed vectors, backpressure, mid-flight reset
// and a random run scored against an arithmetic reference model.
module tb_cla_sum_stage;

    localparam int NRAND  = 10000;
    localparam int MAXCYC = 60000;

    typedef struct packed {
        logic [31:0] s;
        logic        cout;
        logic        v;
        logic        z;
        logic        n;
        logic [3:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] s;
        logic        cout;
        logic        v;
        logic        z;
        logic        n;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A, B, G, P;
    logic [8:0]  C;
    logic [3:0]  tag_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] S;
    logic        Cout, V, Z, N;
    logic [3:0]  tag_out;

    int n_checks = 0;
    int n_errors = 0;

    cla_sum_stage #(.TAG_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .G         (G),
        .P         (P),
        .C         (C),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .V         (V),
        .Z         (Z),
        .N         (N),
        .tag_out   (tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Carry into bit 4k is the carry out of adding the low 4k bits.
    function automatic logic [8:0] lookahead(input logic [31:0] a, input logic [31:0] b, input logic cin);
        logic [8:0]  c;
        logic [63:0] m;
        logic [63:0] s;
        c[0] = cin;
        for (int k = 1; k <= 8; k++) begin
            m    = (64'd1 << (4 * k)) - 64'd1;
            s    = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
            c[k] = s[4*k];
        end
        return c;
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [3:0] tag);
        exp_t        e;
        logic [63:0] u;
        longint      sg;
        u      = {32'd0, a} + {32'd0, b} + {63'd0, cin};
        sg     = longint'($signed(a)) + longint'($signed(b)) + longint'({63'd0, cin});
        e.s    = u[31:0];
        e.cout = u[32];
        e.v    = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
        e.z    = (u[31:0] == 32'd0);
        e.n    = u[31];
        e.tag  = tag;
        return e;
    endfunction

    task automatic set_in(input logic v, input logic [31:0] a, input logic [31:0] b, input logic cin, input logic [3:0] tag);
        in_valid = v;
        A        = a;
        B        = b;
        G        = a & b;
        P        = a | b;
        C        = lookahead(a, b, cin);
        tag_in   = tag;
    endtask

    vec_t        vecs[6];
    exp_t        q[$];
    logic [3:0]  got[$];
    exp_t        e;
    logic [31:0] ra, rb;
    logic        rcin;
    int          n_done, cyc, n_out;
    bit          sent3;

    initial begin
        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{32'h0000000F, 32'h00000000, 1'b1, 32'h00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        rst_n     = 1'b0;
        out_ready = 1'b0;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(S), 64'd0);
        check("rst_flags_tag", 64'({Cout, V, Z, N, tag_out}), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with two-cycle latency check
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            set_in(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, 4'(i));
            @(negedge clk);
            check("dir_in_ready", 64'(in_ready), 64'd1);
            @(posedge clk); #1;
            set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
            @(negedge clk);
            check("dir_valid_early", 64'(out_valid), 64'd0);
            @(posedge clk);
            @(negedge clk);
            check("dir_valid", 64'(out_valid), 64'd1);
            check("dir_sum", 64'(S), 64'(vecs[i].s));
            check("dir_flags_tag", 64'({Cout, V, Z, N, tag_out}),
                  64'({vecs[i].cout, vecs[i].v, vecs[i].z, vecs[i].n, 4'(i)}));
        end

        // Backpressure: tags 1,2 fill the pipe, tag 3 waits
        @(posedge clk); #1;
        out_ready = 1'b0;
        set_in(1'b1, 32'd1, 32'd1, 1'b0, 4'd1);
        @(negedge clk);
        check("bp_ready_t1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        set_in(1'b1, 32'd2, 32'd2, 1'b0, 4'd2);
        @(negedge clk);
        check("bp_ready_t2", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        set_in(1'b1, 32'd3, 32'd3, 1'b0, 4'd3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_full", 64'(in_ready), 64'd0);
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_tag", 64'(tag_out), 64'd1);
            check("bp_hold_sum", 64'(S), 64'd2);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        got.delete();
        sent3 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                got.push_back(tag_out);
                check("bp_drain_sum", 64'(S), 64'(2 * got.size()));
            end
            if (in_valid && in_ready) sent3 = 1'b1;
            @(posedge clk); #1;
            if (sent3) in_valid = 1'b0;
        end
        check("bp_count", 64'(got.size()), 64'd3);
        for (int k = 0; k < 3; k++) begin
            check("bp_order", (k < got.size()) ? 64'(got[k]) : 64'hF, 64'(k + 1));
        end

        // Reset with two transactions in flight
        out_ready = 1'b0;
        set_in(1'b1, 32'h10, 32'h20, 1'b0, 4'd5);
        @(posedge clk); #1;
        set_in(1'b1, 32'h30, 32'h40, 1'b0, 4'd6);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        check("mid_pre_valid", 64'(out_valid), 64'd1);
        check("mid_pre_tag", 64'(tag_out), 64'd5);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_sum", 64'(S), 64'd0);
        check("mid_rst_flags_tag", 64'({Cout, V, Z, N, tag_out}), 64'd0);
        #3;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_in(1'b1, 32'hAAAA5555, 32'h5555AAAB, 1'b0, 4'd7);
        @(negedge clk);
        check("mid_post_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        set_in(1'b0, 32'd0, 32'd0, 1'b0, 4'd0);
        n_out = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (out_valid) begin
                n_out++;
                check("mid_post_tag", 64'(tag_out), 64'd7);
                check("mid_post_sum", 64'(S), 64'd0);
                check("mid_post_flags", 64'({Cout, V, Z, N}), 64'b1010);
            end
        end
        check("mid_post_count", 64'(n_out), 64'd1);

        // Random traffic against the reference model
        q.delete();
        n_done = 0;
        cyc    = 0;
        while (n_done < NRAND && cyc < MAXCYC) begin
            @(posedge clk); #1;
            cyc++;
            ra   = $urandom;
            rb   = ($urandom_range(0, 3) == 0) ? ~ra : $urandom;
            rcin = 1'($urandom_range(0, 1));
            set_in(($urandom_range(0, 3) != 0), ra, rb, rcin, 4'($urandom_range(0, 15)));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("rnd_in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("rnd_spurious_valid", 64'(out_valid), 64'd0);
                end else begin
                    check("rnd_sum", 64'(S), 64'(q[0].s));
                    check("rnd_flags_tag", 64'({Cout, V, Z, N, tag_out}),
                          64'({q[0].cout, q[0].v, q[0].z, q[0].n, q[0].tag}));
                    if (out_ready) begin
                        void'(q.pop_front());
                        n_done++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                e = model(A, B, C[0], tag_in);
                q.push_back(e);
            end
        end
        check("rnd_completed", 64'(n_done), 64'(NRAND));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/cla_sum_stage.md
Name: cla_sum_stage

Overview:
- Downstream consumer of the 32-bit carry-lookahead generate/propagate unit.
- Takes the operands, per-bit G/P and the 9 group carries, then forms in-group carries and the 32-bit sum.
- Produces the carry-out (Cout), signed-overflow (V), zero (Z) and negative (N) flags.
- Two-register pipeline with valid/ready handshake in both directions, so the combinational adder can feed a registered datapath at one result per cycle.

Parameters:
- TAG_W, 4, width of an opaque transaction tag carried alongside the data, unchanged.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream presents a transaction
- in_ready  out  1  stage accepts when in_valid & in_ready
- A  in  32  operand A
- B  in  32  operand B (already inverted upstream for subtract)
- G  in  32  per-bit generate, A&B
- P  in  32  per-bit propagate, A|B (OR form)
- C  in  9  group carries: C[0]=Cin, C[k]=carry into bit 4k, C[8]=carry out
- tag_in  in  TAG_W  transaction tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- S  out  32  sum
- Cout  out  1  carry out of bit 31
- V  out  1  signed overflow
- Z  out  1  S==0
- N  out  1  S[31]
- tag_out  out  TAG_W  tag of the result

Behaviour:
- Clock and reset:
  - Single clock `clk`.
  - `rst_n` is asynchronous, active-low. Assertion immediately clears s1_valid and s2_valid, which forces out_valid=0.
  - All data registers reset to 0, so S, Cout, V, Z, N and tag_out all reset to 0.
  - After deassertion, in_ready=1 on the first edge.
- Stage 1 (capture):
  - Registers A, B, G, P, C and tag_in.
  - Sets s1_valid when in_valid & in_ready.
- Stage 2 (compute + register):
  - Group g (0..7) starts with carry c[4g]=C[g].
  - In-group carry: c[i+1] = G[i] | (P[i] & c[i]), for k=0..2 within the group.
  - Sum: S[i] = A[i]^B[i]^c[i]. XOR comes from A/B, not from P, because P is OR-form.
  - Cout = C[8] of the captured set.
  - V = (A[31]==B[31]) & (S[31]!=A[31]).
  - Z = ~|S; N = S[31].
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Handshake:
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1, which depends only on internal state and out_ready, never on in_valid.
  - Stage 2 loads from stage 1 when adv2. s2_valid <= s1_valid in that case; otherwise s2 holds.
  - Stage 1 loads when adv1. s1_valid <= in_valid in that case.
  - Data registers load only when the corresponding incoming valid is 1, which saves toggling.
- Latency and throughput:
  - 2 cycles from accepted input to out_valid when out_ready is held high.
  - Throughput 1 per cycle.
- Stalls:
  - While out_valid & ~out_ready, S, flags and tag_out stay stable.
  - At most 2 transactions are held in flight; in_ready drops only when both stages are full and out_ready=0.
- Simultaneous accept and drain on a full pipe: no bubble and no loss; the new input enters s1 as s1 moves to s2.
- Reset mid-operation: in-flight transactions are discarded and no partial result is emitted.
- Inputs are assumed consistent (G=A&B, P=A|B, C from the lookahead unit). Inconsistent inputs give undefined S but must not corrupt the handshake.

Decomposition:
- Shared package:
  - Constants WIDTH=32, GRP=4, NGRP=8.
  - A packed flags typedef {Cout,V,Z,N}.
  - A stage-payload struct {A,B,G,P,C,tag}.
- One sub-module, cla_group_sum: purely combinational. Inputs are 4-bit a, b, g, p and cin; output is the 4-bit sum. Instantiated 8 times inside the stage-2 logic.

Test Plan:
- The bench drives A/B/Cin through the existing lookahead unit into this block, with out_ready=1.
- Carry across all groups: A=0xFFFFFFFF, B=0x00000001, Cin=0 -> S=0x00000000, Cout=1, Z=1, V=0, N=0, out_valid exactly 2 cycles after accept.
- Overflow: A=0x7FFFFFFF, B=0x00000001 -> S=0x80000000, V=1, N=1, Cout=0.
- In-group ripple plus Cin: A=0x0000000F, B=0x00000000, Cin=1 -> S=0x00000010. Then A=0x12345678, B=0x9ABCDEF0 -> S=0xACF13568, Cout=0.
- Backpressure: out_ready=0, issue tags 1, 2, 3 back-to-back:
  - Tags 1 and 2 are accepted, then in_ready=0 holding tag 3.
  - S/tag_out stay stable on tag 1.
  - Raise out_ready: outputs 1, 2, 3 in order, with no duplicates or drops.
- Reset mid-flight: 2 transactions in flight, pulse rst_n low asynchronously between edges:
  - out_valid=0 and all outputs=0 immediately.
  - After release, the next transaction emerges alone with the correct sum.
- 10k random A/B/Cin with random in_valid/out_ready:
  - S == A+B+Cin mod 2^32.
  - Flags match a model.
  - Tags stay in order.
